// File: rtl/xt_hb2lb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// xt_hb2lb_bridge_pkg
//   Shared XT_HB / XT_LB bus types for the HB-to-LB bridge.
//   - hb_slave_t        : HB request payload (raddr, waddr, wdata, write_width)
//   - sel_t             : HB window select (ren, wen)
//   - lb_slave_t        : LB initiator strobes (ren, wen, addr, wdata, write_width)
//   - lb_master_rsp_t   : response returned to HB (rvalid, err, rdata)
//   - lb_bridge_state_e : bridge FSM states
//   - InLbWindow()      : true when an HB offset falls inside the 256-word LB window
// ----------------------------------------------------------------------------
package xt_hb2lb_bridge_pkg;

    localparam int HB_ADDR_W   = 14;
    localparam int LB_ADDR_W   = 8;
    localparam int DATA_W      = 32;
    localparam int WW_W        = 2;
    localparam int LB_ADDR_LSB = 2;

    typedef struct packed {
        logic [HB_ADDR_W-1:0] raddr;
        logic [HB_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]    wdata;
        logic [WW_W-1:0]      write_width;
    } hb_slave_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;

    typedef struct packed {
        logic                 ren;
        logic                 wen;
        logic [LB_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]    wdata;
        logic [WW_W-1:0]      write_width;
    } lb_slave_t;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } lb_master_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RESP  = 3'd4
    } lb_bridge_state_e;

    // Every offset bit above the 8-bit LB word index must be clear.
    function automatic logic InLbWindow(input logic [HB_ADDR_W-1:0] offset,
                                        input int unsigned          lsb);
        return (offset >> (lsb + LB_ADDR_W)) == '0;
    endfunction

endpackage

// File: rtl/xt_lb_addr_map.sv
// ----------------------------------------------------------------------------
// xt_lb_addr_map
//   Combinational HB offset -> LB word address translation.
//   Ports:
//     offset_i  in  HB byte offset
//     lb_addr_o out LB word address (offset[ADDR_LSB+7:ADDR_LSB])
//     in_win_o  out offset lies inside the LB window
// ----------------------------------------------------------------------------
module xt_lb_addr_map
    import xt_hb2lb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_LSB = LB_ADDR_LSB
) (
    input  logic [HB_ADDR_W-1:0] offset_i,
    output logic [LB_ADDR_W-1:0] lb_addr_o,
    output logic                 in_win_o
);

    // Bits below ADDR_LSB select a byte within the word and are dropped.
    assign lb_addr_o = offset_i[ADDR_LSB +: LB_ADDR_W];
    assign in_win_o  = InLbWindow(offset_i, ADDR_LSB);

endmodule

// File: rtl/xt_hb2lb_bridge.sv
// ----------------------------------------------------------------------------
// xt_hb2lb_bridge
//   XT_HB slave window -> XT_LB initiator. Converts HB read/write selects into
//   registered single-cycle LB strobes and returns LB read data to HB.
//   Writes are issued before reads when both are selected together.
//
//   Handshake: a request is taken in any cycle where hb_busy=0 and
//   hb_sel.ren|hb_sel.wen is high; selects seen while hb_busy=1 are dropped.
//   hb_rvalid / hb_err are one-cycle pulses; hb_rdata holds until next rvalid.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     hb_in        HB raddr/waddr/wdata/write_width
//     hb_sel       HB ren/wen for this window
//     hb_busy      bridge cannot accept a request this cycle
//     hb_rvalid    read data valid pulse
//     hb_rdata     read data
//     hb_err       out-of-window access pulse
//     lb_out       LB ren/wen/addr/wdata/write_width (registered)
//     lb_rdata     OR of LB slave read data, valid 1 cycle after ren
//     dbg_state_o  current FSM state (debug observation)
//
//   Build option: XT_LB_BRIDGE_POSTED_WRITE_EN - write-only requests do not
//   stall; the WRITE cycle can accept the next request so writes stream
//   one per cycle. Without it a write occupies the bridge for 2 cycles.
// ----------------------------------------------------------------------------
module xt_hb2lb_bridge
    import xt_hb2lb_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_LSB  = LB_ADDR_LSB,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  hb_slave_t         hb_in,
    input  sel_t              hb_sel,
    output logic              hb_busy,
    output logic              hb_rvalid,
    output logic [DATA_W-1:0] hb_rdata,
    output logic              hb_err,
    output lb_slave_t         lb_out,
    input  logic [DATA_W-1:0] lb_rdata,
    output lb_bridge_state_e  dbg_state_o
);

`ifdef XT_LB_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    lb_bridge_state_e state_q, state_d;
    hb_slave_t        req_q, req_d;
    logic             rd_pend_q, rd_pend_d;
    lb_slave_t        lb_q, lb_d;
    lb_master_rsp_t   rsp_q, rsp_d;

    logic                 can_accept;
    logic                 accept;
    logic                 rd_oow_fire;
    logic [LB_ADDR_W-1:0] rd_addr, wr_addr;
    logic                 rd_win, wr_win;

    // A WRITE cycle may take a new request only when no read is queued
    // behind the write being issued.
    assign can_accept = (state_q == ST_IDLE) ||
                        (POSTED && (state_q == ST_WRITE) && !rd_pend_q);
    assign accept     = can_accept && (hb_sel.ren || hb_sel.wen);

    // Decisions in the accept cycle use the incoming request directly.
    assign req_d     = accept ? hb_in : req_q;
    assign rd_pend_d = accept ? hb_sel.ren : rd_pend_q;

    xt_lb_addr_map #(.ADDR_LSB(ADDR_LSB)) u_rd_map (
        .offset_i (req_d.raddr),
        .lb_addr_o(rd_addr),
        .in_win_o (rd_win)
    );

    xt_lb_addr_map #(.ADDR_LSB(ADDR_LSB)) u_wr_map (
        .offset_i (req_d.waddr),
        .lb_addr_o(wr_addr),
        .in_win_o (wr_win)
    );

    // State register and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Next-state logic. An out-of-window read never enters READ: its error
    // response is produced directly at the point it would have been issued.
    always_comb begin
        state_d     = state_q;
        rd_oow_fire = 1'b0;
        if (accept) begin
            if (hb_sel.wen) begin
                state_d = ST_WRITE;
            end else if (rd_win) begin
                state_d = ST_READ;
            end else begin
                state_d     = ST_IDLE;
                rd_oow_fire = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_WRITE: begin
                    if (rd_pend_q && rd_win) begin
                        state_d = ST_READ;
                    end else begin
                        state_d     = ST_IDLE;
                        rd_oow_fire = rd_pend_q;
                    end
                end
                ST_READ:  state_d = ST_RWAIT;
                ST_RWAIT: state_d = ST_RESP;
                ST_RESP:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: all outputs are registers, so their next values are
    // derived from the state being entered.
    always_comb begin
        lb_d            = lb_q;
        lb_d.ren        = 1'b0;
        lb_d.wen        = 1'b0;
        rsp_d           = rsp_q;
        rsp_d.rvalid    = 1'b0;
        rsp_d.err       = 1'b0;

        if (state_d == ST_WRITE) begin
            if (wr_win) begin
                lb_d.wen         = 1'b1;
                lb_d.addr        = wr_addr;
                lb_d.wdata       = req_d.wdata;
                lb_d.write_width = req_d.write_width;
            end else begin
                rsp_d.err = 1'b1;
            end
        end

        if (state_d == ST_READ) begin
            lb_d.ren  = 1'b1;
            lb_d.addr = rd_addr;
        end

        if (state_q == ST_RWAIT) begin
            rsp_d.rdata = lb_rdata;
        end

        if (state_d == ST_RESP) begin
            rsp_d.rvalid = 1'b1;
        end

        if (rd_oow_fire) begin
            rsp_d.rvalid = 1'b1;
            rsp_d.err    = 1'b1;
            rsp_d.rdata  = ERR_RDATA;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q  <= '0;
            rsp_q <= '0;
        end else begin
            lb_q  <= lb_d;
            rsp_q <= rsp_d;
        end
    end

    assign hb_busy     = !can_accept;
    assign hb_rvalid   = rsp_q.rvalid;
    assign hb_err      = rsp_q.err;
    assign hb_rdata    = rsp_q.rdata;
    assign lb_out      = lb_q;
    assign dbg_state_o = state_q;

endmodule
